// File: rtl/cpu_sequencer.sv
// Fetch/execute sequencer: owns pc and ir, stalls on data-memory access, gates writeback.
// Optional CPU_SEQ_TIMEOUT_EN: abort a stalled data access after TIMEOUT MEM cycles (err=1, HALT).
module cpu_sequencer #(
  parameter int PC_W    = 10,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             done,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [8:0]       imem_rdata,
  output logic [8:0]       ir,
  input  logic             mem_access,
  input  logic             branch_req,
  input  logic             cond_met,
  input  logic [PC_W-1:0]  branch_target,
  input  logic             halt,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic             wb_en,
  output logic [CNT_W-1:0] retired,
  output logic             err
);

  // state   | meaning
  // IDLE    | after reset, waiting for start
  // FETCH   | pc presented on imem_addr
  // LATCH   | instruction word captured into ir
  // EXEC    | decode: halt, stall for memory, or commit
  // MEM     | dmem_req held until ack (or timeout)
  // HALT    | program finished, done high, waits for restart
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LATCH, S_EXEC, S_MEM, S_HALT
  } state_t;

  state_t           state_q;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [8:0]       ir_q;
  logic             done_q;
  logic             dmem_req_q;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             commit;

`ifdef CPU_SEQ_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMR_W-1:0] tmr_q;
  logic             err_q;
`endif

  // Writeback is a same-cycle strobe so the register file commits with the decoder outputs still valid.
  assign commit = ((state_q == S_EXEC) && !halt && !mem_access) ||
                  ((state_q == S_MEM) && dmem_ack);
  assign pc_d      = (branch_req && cond_met) ? branch_target : pc_q + 1'b1;
  assign retired_d = (&retired_q) ? retired_q : retired_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      done_q     <= 1'b0;
      dmem_req_q <= 1'b0;
      retired_q  <= '0;
`ifdef CPU_SEQ_TIMEOUT_EN
      tmr_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            pc_q      <= '0;
            retired_q <= '0;
            done_q    <= 1'b0;
`ifdef CPU_SEQ_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
            state_q   <= S_FETCH;
          end
        end
        S_FETCH: state_q <= S_LATCH;
        S_LATCH: begin
          ir_q    <= imem_rdata;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (halt) begin
            done_q  <= 1'b1;
            state_q <= S_HALT;
          end else if (mem_access) begin
            dmem_req_q <= 1'b1;
`ifdef CPU_SEQ_TIMEOUT_EN
            tmr_q      <= TMR_W'(TIMEOUT - 1);
`endif
            state_q    <= S_MEM;
          end else begin
            pc_q      <= pc_d;
            retired_q <= retired_d;
            state_q   <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            dmem_req_q <= 1'b0;
            pc_q       <= pc_d;
            retired_q  <= retired_d;
            state_q    <= S_FETCH;
          end
`ifdef CPU_SEQ_TIMEOUT_EN
          else if (tmr_q == '0) begin
            dmem_req_q <= 1'b0;
            err_q      <= 1'b1;
            done_q     <= 1'b1;
            state_q    <= S_HALT;
          end else begin
            tmr_q <= tmr_q - 1'b1;
          end
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign done      = done_q;
  assign dmem_req  = dmem_req_q;
  assign wb_en     = commit;
  assign retired   = retired_q;
`ifdef CPU_SEQ_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: instruction memory model, tiny decoder, linear stimulus.
// Timeout section follows CPU_SEQ_TIMEOUT_EN when the bench is built with it.
module tb_cpu_sequencer;
  localparam int PC_W = 10;
  localparam int CNT_W = 16;
  localparam logic [8:0] OP_ALU = 9'h012, OP_LOAD = 9'h0A3,
                         OP_BR  = 9'h134, OP_HALT = 9'h1C5;

  logic clk = 1'b0;
  logic reset, start, dmem_ack, cond_met;
  logic [PC_W-1:0] branch_target, imem_addr;
  logic [8:0] imem_rdata, ir;
  logic done, dmem_req, wb_en, err;
  logic mem_access, branch_req, halt;
  logic [CNT_W-1:0] retired;
  logic [8:0] mem [1024];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .ir(ir),
    .mem_access(mem_access), .branch_req(branch_req), .cond_met(cond_met),
    .branch_target(branch_target), .halt(halt), .dmem_req(dmem_req),
    .dmem_ack(dmem_ack), .wb_en(wb_en), .retired(retired), .err(err)
  );

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  assign halt       = (ir[8:7] == 2'b11);
  assign mem_access = (ir[8:7] == 2'b01);
  assign branch_req = (ir[8:7] == 2'b10);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_alu();
    for (int a = 0; a < 1024; a++) mem[a] = OP_ALU;
  endtask

  task automatic kick();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wb_m, done_m, req_m;
    int n, req_cnt, wb_cnt;
    logic [PC_W-1:0] addr7;
    logic [CNT_W-1:0] ret7;

    reset = 1'b1; start = 1'b0; dmem_ack = 1'b0; cond_met = 1'b0; branch_target = '0;
    fill_alu();
    mem[3] = OP_HALT;
    step(2);
    reset = 1'b0;
    #1;
    chk("rst_done", done, 0);
    chk("rst_req", dmem_req, 0);
    chk("rst_wb", wb_en, 0);
    chk("rst_retired", retired, 0);
    chk("rst_err", err, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_ir", ir, 0);

    // three ALU ops then halt at address 3
    kick();
    wb_m = '0; done_m = '0;
    for (int c = 1; c <= 14; c++) begin
      #1;
      wb_m[c] = wb_en;
      done_m[c] = done;
      step(1);
    end
    chk("alu_wb_cycles", wb_m, 16'h0248);
    chk("alu_done_cycles", done_m, 16'h6000);
    chk("alu_retired", retired, 3);
    chk("alu_pc", imem_addr, 3);
    chk("alu_ir_halt", ir, OP_HALT);

    // load at 0, ack 2 cycles after MEM entry, stray ack in LATCH; then taken branch at 5
    fill_alu();
    mem[0] = OP_LOAD; mem[5] = OP_BR; mem[20] = OP_HALT; mem[6] = OP_HALT;
    cond_met = 1'b1; branch_target = 10'd20;
    kick();
    chk("restart_done", done, 0);
    chk("restart_retired", retired, 0);
    req_m = '0; wb_m = '0; addr7 = '0; ret7 = '0;
    for (int c = 1; c <= 7; c++) begin
      dmem_ack = (c == 2 || c == 6);
      #1;
      req_m[c] = dmem_req;
      wb_m[c] = wb_en;
      if (c == 7) begin
        addr7 = imem_addr;
        ret7 = retired;
      end
      step(1);
    end
    dmem_ack = 1'b0;
    chk("load_req_cycles", req_m, 16'h0070);
    chk("load_wb_cycles", wb_m, 16'h0040);
    chk("load_next_addr", addr7, 1);
    chk("load_retired", ret7, 1);
    n = 0;
    while (imem_addr !== 10'd5 && n < 40) begin step(1); n++; end
    chk("reach_addr5_taken", (n < 40), 1);
    step(3);
    chk("branch_taken_addr", imem_addr, 20);
    chk("branch_taken_retired", retired, 6);
    n = 0;
    while (done !== 1'b1 && n < 10) begin step(1); n++; end
    chk("halt20_done", done, 1);
    chk("halt20_retired", retired, 6);
    chk("halt20_pc", imem_addr, 20);

    // same program, branch not taken; load acked in its first MEM cycle
    cond_met = 1'b0;
    kick();
    n = 0;
    while (imem_addr !== 10'd5 && n < 40) begin dmem_ack = dmem_req; step(1); n++; end
    dmem_ack = 1'b0;
    chk("reach_addr5_nt", (n < 40), 1);
    step(3);
    chk("branch_nt_addr", imem_addr, 6);
    n = 0;
    while (done !== 1'b1 && n < 10) begin step(1); n++; end
    chk("halt6_done", done, 1);
    chk("halt6_retired", retired, 6);
    chk("halt6_ir", ir, OP_HALT);

    // pc wrap: branch 0 -> 1023, ALU at 1023 wraps to 0
    fill_alu();
    mem[0] = OP_BR;
    cond_met = 1'b1; branch_target = 10'd1023;
    kick();
    step(3);
    chk("wrap_at_1023", imem_addr, 1023);
    step(3);
    chk("wrap_to_0", imem_addr, 0);
    chk("wrap_retired", retired, 2);

    // reset while stalled in MEM
    reset = 1'b1; step(1); reset = 1'b0;
    mem[0] = OP_ALU; mem[1] = OP_LOAD;
    cond_met = 1'b0;
    kick();
    step(6);
    chk("mem_req_before_rst", dmem_req, 1);
    chk("mem_retired_before_rst", retired, 1);
    step(2);
    reset = 1'b1; step(1); reset = 1'b0;
    chk("midrst_req", dmem_req, 0);
    chk("midrst_retired", retired, 0);
    chk("midrst_wb", wb_en, 0);
    chk("midrst_addr", imem_addr, 0);
    chk("midrst_ir", ir, 0);
    chk("midrst_done", done, 0);
    step(3);
    chk("idle_holds_addr", imem_addr, 0);
    chk("idle_holds_req", dmem_req, 0);
    kick();
    step(2);
    chk("rerun_ir0", ir, OP_ALU);
    chk("rerun_wb", wb_en, 1);

    // load at 1 with no ack ever
    req_cnt = 0; wb_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (dmem_req) req_cnt++;
      if (wb_en) wb_cnt++;
    end
`ifdef CPU_SEQ_TIMEOUT_EN
    chk("to_req_cycles", req_cnt, 16);
    chk("to_err", err, 1);
    chk("to_done", done, 1);
`else
    chk("noto_req_cycles", req_cnt, 37);
    chk("noto_err", err, 0);
    chk("noto_done", done, 0);
`endif
    chk("stall_no_wb", wb_cnt, 0);
    chk("stall_retired", retired, 1);
    reset = 1'b1; step(1); reset = 1'b0;
    kick();
    chk("err_clear", err, 0);
    chk("err_clear_done", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
